inst_loader: RTL and testbench
==============================

Name: inst_loader

Overview:
- Writer side of the instruction memory.
- Receives a program image as a byte stream (valid/ready), packs bytes into 32-bit words in the instruction-memory storage byte order, and issues write strobes into the instruction RAM.
- Holds the CPU via cpu_hold while a load is in progress.
- Sits between a UART/byte source and the write port of the instruction RAM that the fetch path reads.

Parameters:
ADDR_WIDTH, 10, word-address width of the instruction RAM; capacity is 2**ADDR_WIDTH words.

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse; begins a load when idle, done or error
rx_data  input  8  incoming byte
rx_valid  input  1  rx_data valid
rx_ready  output  1  loader accepts a byte this cycle
wr_en  output  1  instruction RAM write strobe, one cycle per word
wr_addr  output  32  byte address of the word being written; always word aligned
wr_data  output  32  word to store
cpu_hold  output  1  high while loading or in error; holds the CPU in reset
busy  output  1  high in LEN_LO, LEN_HI, DATA, CHECK
done  output  1  high in DONE state
error  output  1  high in ERROR state

Behaviour:
- Reset: state IDLE. rx_ready, wr_en, cpu_hold, busy, done and error are 0; wr_addr and wr_data are 0; internal word index, byte index and checksum are 0.
- Byte acceptance: a byte is accepted on a clock edge where rx_valid && rx_ready. rx_ready is high only in LEN_LO, LEN_HI, DATA and CHECK.
- IDLE/DONE/ERROR, on start:
  - go to LEN_LO; clear indices and checksum; clear done/error; assert cpu_hold.
  - start in any busy state is ignored.
- LEN_LO: the accepted byte becomes length[7:0]; go to LEN_HI.
- LEN_HI: the accepted byte becomes length[15:8], where length is a word count.
  - length == 0: go to DONE (or CHECK when the checksum feature is enabled).
  - length > 2**ADDR_WIDTH: go to ERROR.
  - otherwise: go to DATA.
- DATA:
  - Bytes are packed first-byte-into-[31:24], i.e. bytes b0,b1,b2,b3 give {b0,b1,b2,b3}.
  - On acceptance of the 4th byte, in the following cycle: wr_en=1, wr_data = packed word, wr_addr = word_index<<2.
  - word_index then increments; wr_en is high for exactly one cycle.
  - After the write of word length-1, go to DONE (or CHECK).
- Latency: 4th byte accepted at edge N; wr_en is high during cycle N+1.
- rx_valid low mid-word: byte index holds and no write is issued. There is no timeout.
- DONE: done=1, cpu_hold=0; remains until start or reset. wr_data/wr_addr hold their last values.
- ERROR: error=1, cpu_hold=1; remains until start or reset. No writes occur in ERROR.
- Reset mid-load: return to IDLE the next edge with no write issued; partial RAM contents are left as-is.
- wr_addr bits above ADDR_WIDTH+1 are 0; word_index never exceeds 2**ADDR_WIDTH-1.

Optional Feature:
- Macro: INST_LOADER_CHECKSUM_EN.
- Enabled:
  - An 8-bit running XOR of all DATA bytes is kept, not including the length bytes.
  - After the final data write (or immediately after LEN_HI when length==0), the block enters CHECK and accepts one byte.
  - Equal to the running XOR: go to DONE. Otherwise: go to ERROR.
- Disabled: CHECK state and checksum register are absent; DATA goes directly to DONE.

Decomposition:
- Package inst_loader_pkg:
  - state encoding constants: IDLE, LEN_LO, LEN_HI, DATA, CHECK, DONE, ERROR;
  - BYTES_PER_WORD=4;
  - width constants for byte index (2) and length (16).
- One sub-module, inst_byte_packer:
  - 4-byte shift/pack register with byte counter;
  - emits word_valid with the packed word when the 4th byte lands;
  - clearable by start/reset.
- The FSM, address counter and checksum stay in inst_loader.

Test Plan:
1. Start; send length 0x0002 and bytes 20,08,00,05,00,00,00,00 -> wr_en pulses twice: addr 0x0 data 0x20080005, then addr 0x4 data 0x00000000; done=1, cpu_hold=0.
2. Length 0x0000 -> no wr_en, done=1 two accepted bytes after start; with the checksum feature, a checksum byte 0x00 is required first.
3. Length 0x0401 with ADDR_WIDTH=10 -> error=1, cpu_hold=1, no wr_en; a subsequent start and a valid load succeeds.
4. rx_valid toggled every other cycle during a 3-word load -> exactly 3 writes; addresses 0x0, 0x4, 0x8; data is byte-exact.
5. reset asserted after 2 data bytes -> all outputs return to reset values the next edge; no wr_en; a new start loads word 0 at 0x0.
6. With INST_LOADER_CHECKSUM_EN: 1 word DEADBEEF, checksum 0x22 -> done; checksum 0x23 -> error, with the word still written.

Source files
------------

// File: rtl/inst_loader_pkg.sv
// Shared constants for the instruction loader: state encodings and field widths.
package inst_loader_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LEN_LO = 3'd1;
  localparam logic [2:0] ST_LEN_HI = 3'd2;
  localparam logic [2:0] ST_DATA   = 3'd3;
  localparam logic [2:0] ST_CHECK  = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;
  localparam logic [2:0] ST_ERROR  = 3'd6;

  localparam int BYTES_PER_WORD = 4;
  localparam int BIDX_W         = 2;
  localparam int LEN_W          = 16;

  typedef logic [LEN_W-1:0] len_t;

endpackage

// File: rtl/inst_byte_packer.sv
// Packs a byte stream into 32-bit words, first byte into [31:24].
// word_valid pulses for one cycle after the edge that accepts the 4th byte.
module inst_byte_packer
  import inst_loader_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        last_byte,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [BIDX_W-1:0] byte_idx;
  logic [23:0]       shift;

  assign last_byte = byte_valid && (byte_idx == BIDX_W'(BYTES_PER_WORD - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      byte_idx   <= '0;
      shift      <= '0;
      word_valid <= 1'b0;
      word       <= '0;
    end else begin
      word_valid <= 1'b0;
      if (clear) begin
        byte_idx <= '0;
        shift    <= '0;
      end else if (byte_valid) begin
        // byte_idx wraps to 0 after the 4th byte, ready for the next word
        byte_idx <= byte_idx + BIDX_W'(1);
        shift    <= {shift[15:0], byte_data};
        if (last_byte) begin
          word_valid <= 1'b1;
          word       <= {shift, byte_data};
        end
      end
    end
  end

endmodule

// File: rtl/inst_loader.sv
// Instruction-memory loader: length-prefixed byte stream -> word writes, holds the CPU while loading.
// Optional trailing XOR checksum byte when INST_LOADER_CHECKSUM_EN is defined.
module inst_loader
  import inst_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        error
);

`ifdef INST_LOADER_CHECKSUM_EN
  localparam logic [2:0] ST_AFTER_DATA = ST_CHECK;
`else
  localparam logic [2:0] ST_AFTER_DATA = ST_DONE;
`endif

  logic [2:0]            state;
  len_t                  length;
  len_t                  full_len;
  logic [ADDR_WIDTH-1:0] word_index;
  logic                  accept;
  logic                  data_accept;
  logic                  start_ok;
  logic                  last_byte;
  logic                  last_word;
  logic                  too_long;
`ifdef INST_LOADER_CHECKSUM_EN
  logic [7:0]            csum;
`endif

  assign busy     = state inside {ST_LEN_LO, ST_LEN_HI, ST_DATA, ST_CHECK};
  assign rx_ready = busy;
  assign done     = (state == ST_DONE);
  assign error    = (state == ST_ERROR);
  assign cpu_hold = busy || error;

  assign accept      = rx_valid && rx_ready;
  assign data_accept = accept && (state == ST_DATA);
  assign start_ok    = start && (state inside {ST_IDLE, ST_DONE, ST_ERROR});

  assign full_len  = {rx_data, length[7:0]};
  assign too_long  = 32'(full_len) > (32'd1 << ADDR_WIDTH);
  assign last_word = 32'(word_index) == (32'(length) - 32'd1);

  inst_byte_packer u_packer (
    .clock      (clock),
    .reset      (reset),
    .clear      (start_ok),
    .byte_valid (data_accept),
    .byte_data  (rx_data),
    .last_byte  (last_byte),
    .word_valid (wr_en),
    .word       (wr_data)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      length     <= '0;
      word_index <= '0;
      wr_addr    <= '0;
`ifdef INST_LOADER_CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start) begin
            state      <= ST_LEN_LO;
            word_index <= '0;
`ifdef INST_LOADER_CHECKSUM_EN
            csum       <= '0;
`endif
          end
        end
        ST_LEN_LO: begin
          if (accept) begin
            length[7:0] <= rx_data;
            state       <= ST_LEN_HI;
          end
        end
        ST_LEN_HI: begin
          if (accept) begin
            length[15:8] <= rx_data;
            if (full_len == '0)
              state <= ST_AFTER_DATA;
            else if (too_long)
              state <= ST_ERROR;
            else
              state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (data_accept) begin
`ifdef INST_LOADER_CHECKSUM_EN
            csum <= csum ^ rx_data;
`endif
            // wr_addr lands together with the packer's word_valid on the same edge
            if (last_byte) begin
              wr_addr <= 32'({word_index, 2'b00});
              if (last_word)
                state <= ST_AFTER_DATA;
              else
                word_index <= word_index + ADDR_WIDTH'(1);
            end
          end
        end
`ifdef INST_LOADER_CHECKSUM_EN
        ST_CHECK: begin
          if (accept)
            state <= (rx_data == csum) ? ST_DONE : ST_ERROR;
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_loader.sv
// Randomized self-checking bench for inst_loader against a stream-level reference model.
module tb_inst_loader;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        error;

  int vectors     = 0;
  int miscompares = 0;

  logic [63:0] got_q[$];
  logic [63:0] exp_q[$];
  logic [7:0]  img[$];

  inst_loader #(.ADDR_WIDTH(10)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .cpu_hold (cpu_hold),
    .busy     (busy),
    .done     (done),
    .error    (error)
  );

  always #5 clock = ~clock;

  always @(negedge clock)
    if (wr_en) got_q.push_back({wr_addr, wr_data});

`ifdef INST_LOADER_CHECKSUM_EN
  task automatic add_check(input bit good);
    logic [7:0] x;
    x = 8'h00;
    for (int i = 2; i < img.size(); i++) x ^= img[i];
    img.push_back(good ? x : (x ^ 8'h01));
  endtask
  `define ADD_CHECK(g) add_check(g)
`else
  `define ADD_CHECK(g)
`endif

  task automatic pulse_start();
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) begin
      @(negedge clock);
      rx_valid = 1'b0;
    end
    @(negedge clock);
    rx_valid = 1'b1;
    rx_data  = b;
    n = 0;
    while (!rx_ready && n < 40) begin
      @(negedge clock);
      n++;
    end
    vectors++;
    if (!rx_ready) begin
      miscompares++;
      $display("FAIL byte_accept: rx_ready=%0b after %0d cycles, required 1", rx_ready, n);
      rx_valid = 1'b0;
    end else begin
      @(posedge clock);
    end
  endtask

  // Model: length word-count prefix, 4 bytes per word big-end first, optional XOR trailer.
  task automatic run_load(input string name, input int gap, input bit poke);
    int len, nbytes, g;
    bit exp_err;
    logic [7:0] x;
    len = int'(img[0]) | (int'(img[1]) << 8);
    exp_q.delete();
    exp_err = 1'b0;
    if (len > 1024) begin
      exp_err = 1'b1;
      nbytes  = 2;
    end else begin
      nbytes = 2 + 4 * len;
      for (int i = 0; i < len; i++)
        exp_q.push_back({32'(4 * i), img[2+4*i], img[3+4*i], img[4+4*i], img[5+4*i]});
`ifdef INST_LOADER_CHECKSUM_EN
      x = 8'h00;
      for (int i = 2; i < nbytes; i++) x ^= img[i];
      exp_err = (img[nbytes] != x);
      nbytes++;
`endif
    end

    pulse_start();
    got_q.delete();
    vectors++;
    if ({busy, cpu_hold, rx_ready, done, error} !== 5'b11100) begin
      miscompares++;
      $display("FAIL %s start_flags: busy/hold/ready/done/err=%b required 11100", name,
               {busy, cpu_hold, rx_ready, done, error});
    end

    for (int i = 0; i < nbytes; i++) begin
      if (poke && i == 3) begin
        @(negedge clock);
        rx_valid = 1'b0;
        start    = 1'b1;
        @(negedge clock);
        start    = 1'b0;
      end
      g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
      send_byte(img[i], (i == 0) ? 0 : g);
    end
    @(negedge clock);
    rx_valid = 1'b0;
    repeat (3) @(negedge clock);

    vectors++;
    if (got_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL %s write_count: got %0d required %0d", name, got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL %s write[%0d]: addr/data got %h_%h required %h_%h", name, i,
                 got_q[i][63:32], got_q[i][31:0], exp_q[i][63:32], exp_q[i][31:0]);
      end
    end
    vectors++;
    if ({done, error, cpu_hold, busy, rx_ready} !== {!exp_err, exp_err, exp_err, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL %s end_flags: done/err/hold/busy/ready=%b required %b", name,
               {done, error, cpu_hold, busy, rx_ready}, {!exp_err, exp_err, exp_err, 2'b00});
    end
  endtask

  task automatic check_idle_outputs(input string name);
    vectors++;
    if ({rx_ready, wr_en, cpu_hold, busy, done, error} !== 6'b0 || wr_addr !== 32'h0 ||
        wr_data !== 32'h0) begin
      miscompares++;
      $display("FAIL %s: ready/wen/hold/busy/done/err=%b addr=%h data=%h required all zero", name,
               {rx_ready, wr_en, cpu_hold, busy, done, error}, wr_addr, wr_data);
    end
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(negedge clock);
    check_idle_outputs("reset_state");
    reset = 1'b0;
    @(negedge clock);
    check_idle_outputs("idle_after_reset");
  endtask

  task automatic test_basic();
    img = {8'h02, 8'h00, 8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00};
    `ADD_CHECK(1);
    run_load("basic", 0, 1'b0);
  endtask

  task automatic test_zero_length();
    img = {8'h00, 8'h00};
    `ADD_CHECK(1);
    run_load("zero_len", 0, 1'b0);
  endtask

  task automatic test_oversize();
    img = {8'h01, 8'h04};
    run_load("oversize", 0, 1'b0);
    img = {8'h01, 8'h00, 8'h12, 8'h34, 8'h56, 8'h78};
    `ADD_CHECK(1);
    run_load("after_error", 0, 1'b0);
  endtask

  task automatic test_gapped();
    img = {8'h03, 8'h00};
    for (int i = 0; i < 12; i++) img.push_back(8'($urandom));
    `ADD_CHECK(1);
    run_load("gapped", 1, 1'b0);
  endtask

  task automatic test_start_ignored();
    img = {8'h02, 8'h00};
    for (int i = 0; i < 8; i++) img.push_back(8'($urandom));
    `ADD_CHECK(1);
    run_load("start_while_busy", 0, 1'b1);
  endtask

  task automatic test_reset_mid();
    pulse_start();
    got_q.delete();
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'hA5, 0);
    send_byte(8'h5A, 0);
    @(negedge clock);
    rx_valid = 1'b0;
    reset    = 1'b1;
    @(posedge clock);
    #1;
    check_idle_outputs("reset_mid_load");
    vectors++;
    if (got_q.size() != 0) begin
      miscompares++;
      $display("FAIL reset_mid_writes: got %0d required 0", got_q.size());
    end
    @(negedge clock);
    reset = 1'b0;
    img = {8'h01, 8'h00, 8'hCA, 8'hFE, 8'hF0, 8'h0D};
    `ADD_CHECK(1);
    run_load("after_reset", 0, 1'b0);
  endtask

  task automatic test_max_length();
    img = {8'h00, 8'h04};
    for (int i = 0; i < 4096; i++) img.push_back(8'($urandom));
    `ADD_CHECK(1);
    run_load("max_len", 0, 1'b0);
  endtask

  task automatic test_checksum();
`ifdef INST_LOADER_CHECKSUM_EN
    img = {8'h01, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22};
    run_load("csum_good", 0, 1'b0);
    img = {8'h01, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h23};
    run_load("csum_bad", 0, 1'b0);
    img = {8'h00, 8'h00, 8'h07};
    run_load("csum_zero_len_bad", 0, 1'b0);
`endif
  endtask

  task automatic test_random();
    int len;
    for (int it = 0; it < 10; it++) begin
      len = int'($urandom_range(1, 6));
      img = {8'(len), 8'h00};
      for (int i = 0; i < 4 * len; i++) img.push_back(8'($urandom));
      `ADD_CHECK($urandom_range(0, 3) != 0);
      run_load("random", -1, 1'b0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_zero_length();
    test_oversize();
    test_gapped();
    test_start_ignored();
    test_reset_mid();
    test_max_length();
    test_checksum();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
